// File: rtl/checker_pkg.sv
// Shared types for the data-memory write checker: run states, failure codes and
// a width helper that keeps index ports at least one bit wide.
package checker_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StPass = 2'd2,
      StFail = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FailNone     = 2'd0,
      FailMismatch = 2'd1,
      FailTimeout  = 2'd2
   } fail_code_e;

   // A one-entry table still needs a one-bit index port.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_timer.sv
// Cycle counter for a check run: cleared when a run starts, counts while enabled,
// and flags the last permitted cycle (count == TIMEOUT-1).
module run_timer #(
   parameter  int unsigned TIMEOUT = 1024,
   localparam int unsigned CycW    = $clog2(TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear_i,
   input  logic            en_i,
   output logic [CycW-1:0] count_o,
   output logic            tc_o
);

   logic [CycW-1:0] count_q;

   // Clear has priority so a restart always begins from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + CycW'(1);
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == CycW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_write_checker.sv
// Watches the data-memory write port and checks it against a loadable table of
// expected (address, data) writes, in index order or any order, with a bounded
// run length. Reports done/pass plus a failure code for benches and LEDs.
module mem_write_checker
   import checker_pkg::*;
#(
   parameter  int unsigned N       = 32,
   parameter  int unsigned A       = 32,
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned TIMEOUT = 1024,
   parameter  bit          ORDERED = 1'b1,
   localparam int unsigned IdxW    = idx_width(DEPTH),
   localparam int unsigned CntW    = $clog2(DEPTH + 1),
   localparam int unsigned CycW    = $clog2(TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            load_en,
   input  logic [IdxW-1:0] load_idx,
   input  logic [A-1:0]    load_addr,
   input  logic [N-1:0]    load_data,
   input  logic            memwrite,
   input  logic [A-1:0]    dataadr,
   input  logic [N-1:0]    writedata,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [1:0]      fail_code,
   output logic [CntW-1:0] match_count,
   output logic [CycW-1:0] cycles
);

   state_e          state_q;
   fail_code_e      fail_q;
   logic            busy_q, done_q, pass_q;
   logic [CntW-1:0] cnt_q;
   logic [A-1:0]    tbl_addr_q [DEPTH];
   logic [N-1:0]    tbl_data_q [DEPTH];
   logic [DEPTH-1:0] hit_q;

   logic             found, data_eq;
   logic [DEPTH-1:0] hit_set;
   logic             wr_hit, wr_miss, wr_done;
   logic             run_start, tc;

   assign run_start = start && (state_q != StRun);

   run_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_run_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (run_start),
      .en_i    (state_q == StRun),
      .count_o (cycles),
      .tc_o    (tc)
   );

   // Pick the candidate entry for this write: the next in order, or the lowest unhit
   // entry whose address matches. Writes to unrelated addresses select nothing.
   always_comb begin
      found   = 1'b0;
      data_eq = 1'b0;
      hit_set = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!found && (ORDERED ? (CntW'(i) == cnt_q) : !hit_q[i]) &&
             (tbl_addr_q[i] == dataadr)) begin
            found      = 1'b1;
            data_eq    = (tbl_data_q[i] == writedata);
            hit_set[i] = 1'b1;
         end
      end
   end

   assign wr_hit  = memwrite && found && data_eq;
   assign wr_miss = memwrite && found && !data_eq;
   assign wr_done = wr_hit && (cnt_q == CntW'(DEPTH - 1));

   // Table loads plus the run FSM; completing match beats mismatch beats timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         fail_q  <= FailNone;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         cnt_q   <= '0;
         hit_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tbl_addr_q[i] <= '0;
            tbl_data_q[i] <= '0;
         end
      end else begin
         // Out-of-range indices match no entry and are dropped.
         if (load_en && (state_q != StRun)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (32'(load_idx) == i) begin
                  tbl_addr_q[i] <= load_addr;
                  tbl_data_q[i] <= load_data;
               end
            end
         end
         unique case (state_q)
            StRun: begin
               if (wr_hit) begin
                  cnt_q <= cnt_q + CntW'(1);
                  hit_q <= hit_q | hit_set;
               end
               if (wr_done) begin
                  state_q <= StPass;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= 1'b1;
               end else if (wr_miss) begin
                  state_q <= StFail;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  fail_q  <= FailMismatch;
               end else if (tc) begin
                  state_q <= StFail;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  fail_q  <= FailTimeout;
               end
            end
            StIdle, StPass, StFail: begin
               if (start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  fail_q  <= FailNone;
                  cnt_q   <= '0;
                  hit_q   <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail_code   = fail_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: three instances (ordered and unordered 4-entry
// tables with a 16-cycle limit, and a 1-entry table with an 8-cycle limit) share
// stimulus and are compared with a table-level reference model.
module tb_mem_write_checker;

   localparam int MIdle = 0, MRun = 1, MPass = 2, MFail = 3;

   logic        clk = 1'b0;
   logic        reset, start, load_en, memwrite;
   logic [1:0]  load_idx;
   logic [31:0] load_addr, load_data, dataadr, writedata;

   wire       b0, b1, b2, d0, d1, d2, p0, p1, p2;
   wire [1:0] f0, f1, f2;
   wire [2:0] mc0, mc1;
   wire [0:0] mc2;
   wire [4:0] cy0, cy1;
   wire [3:0] cy2;

   logic [31:0] o_busy [3], o_done [3], o_pass [3], o_code [3], o_mc [3], o_cyc [3];

   int errors = 0;
   int checks = 0;

   // Reference model: per-instance expected-write table and run status.
   int          dep [3] = '{4, 4, 1};
   int          tmo [3] = '{16, 16, 8};
   bit          ord [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m_addr [3][4];
   logic [31:0] m_data [3][4];
   bit          m_hit  [3][4];
   int          m_st [3], m_cnt [3], m_cyc [3], m_code [3];

   always #5 clk = ~clk;

   mem_write_checker #(.N(32), .A(32), .DEPTH(4), .TIMEOUT(16), .ORDERED(1'b1)) u_ord (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_idx(load_idx),
      .load_addr(load_addr), .load_data(load_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(b0), .done(d0), .pass(p0), .fail_code(f0),
      .match_count(mc0), .cycles(cy0)
   );

   mem_write_checker #(.N(32), .A(32), .DEPTH(4), .TIMEOUT(16), .ORDERED(1'b0)) u_any (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_idx(load_idx),
      .load_addr(load_addr), .load_data(load_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(b1), .done(d1), .pass(p1), .fail_code(f1),
      .match_count(mc1), .cycles(cy1)
   );

   mem_write_checker #(.N(32), .A(32), .DEPTH(1), .TIMEOUT(8), .ORDERED(1'b1)) u_one (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_idx(load_idx[0:0]),
      .load_addr(load_addr), .load_data(load_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(b2), .done(d2), .pass(p2), .fail_code(f2),
      .match_count(mc2), .cycles(cy2)
   );

   always_comb begin
      o_busy[0] = 32'(b0);  o_busy[1] = 32'(b1);  o_busy[2] = 32'(b2);
      o_done[0] = 32'(d0);  o_done[1] = 32'(d1);  o_done[2] = 32'(d2);
      o_pass[0] = 32'(p0);  o_pass[1] = 32'(p1);  o_pass[2] = 32'(p2);
      o_code[0] = 32'(f0);  o_code[1] = 32'(f1);  o_code[2] = 32'(f2);
      o_mc[0]   = 32'(mc0); o_mc[1]   = 32'(mc1); o_mc[2]   = 32'(mc2);
      o_cyc[0]  = 32'(cy0); o_cyc[1]  = 32'(cy1); o_cyc[2]  = 32'(cy2);
   end

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_st[k] = MIdle; m_cnt[k] = 0; m_cyc[k] = 0; m_code[k] = 0;
         for (int i = 0; i < 4; i++) begin
            m_addr[k][i] = '0; m_data[k][i] = '0; m_hit[k][i] = 1'b0;
         end
      end
   endtask

   // Apply the inputs present at the coming clock edge to the model.
   task automatic model_step();
      int idx, j;
      bit ok;
      for (int k = 0; k < 3; k++) begin
         idx = (k == 2) ? int'(load_idx[0]) : int'(load_idx);
         if (m_st[k] != MRun) begin
            if (load_en && idx < dep[k]) begin
               m_addr[k][idx] = load_addr;
               m_data[k][idx] = load_data;
            end
            if (start) begin
               m_st[k] = MRun; m_cnt[k] = 0; m_cyc[k] = 0; m_code[k] = 0;
               for (int i = 0; i < 4; i++) m_hit[k][i] = 1'b0;
            end
         end else begin
            m_cyc[k]++;
            j = -1;
            if (memwrite) begin
               for (int i = 0; i < dep[k]; i++) begin
                  if (j < 0 && m_addr[k][i] == dataadr &&
                      (ord[k] ? (i == m_cnt[k]) : !m_hit[k][i])) j = i;
               end
            end
            ok = (j >= 0) && (m_data[k][j] == writedata);
            if (ok) begin
               m_hit[k][j] = 1'b1;
               m_cnt[k]++;
            end
            if (m_cnt[k] == dep[k]) begin
               m_st[k] = MPass;
            end else if (j >= 0 && !ok) begin
               m_st[k] = MFail; m_code[k] = 1;
            end else if (m_cyc[k] == tmo[k]) begin
               m_st[k] = MFail; m_code[k] = 2;
            end
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; load_en = 1'b0; memwrite = 1'b0;
      load_idx = '0; load_addr = '0; load_data = '0; dataadr = '0; writedata = '0;
   endtask

   task automatic load(input int idx, input int addr, input int data);
      load_en = 1'b1; load_idx = 2'(idx); load_addr = 32'(addr); load_data = 32'(data);
      cycle();
      load_en = 1'b0;
   endtask

   task automatic write(input int addr, input int data);
      memwrite = 1'b1; dataadr = 32'(addr); writedata = 32'(data);
      cycle();
      memwrite = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Let every model run finish so the next start is accepted everywhere.
   task automatic drain();
      for (int t = 0; t < 40 && (m_st[0] == MRun || m_st[1] == MRun || m_st[2] == MRun); t++)
         cycle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (o_busy[k] !== 0) begin errors++; $display("FAIL reset_busy[%0d] got %0d want 0", k, o_busy[k]); end
         checks++; if (o_done[k] !== 0) begin errors++; $display("FAIL reset_done[%0d] got %0d want 0", k, o_done[k]); end
         checks++; if (o_pass[k] !== 0) begin errors++; $display("FAIL reset_pass[%0d] got %0d want 0", k, o_pass[k]); end
         checks++; if (o_code[k] !== 0) begin errors++; $display("FAIL reset_code[%0d] got %0d want 0", k, o_code[k]); end
         checks++; if (o_mc[k] !== 0) begin errors++; $display("FAIL reset_mc[%0d] got %0d want 0", k, o_mc[k]); end
         checks++; if (o_cyc[k] !== 0) begin errors++; $display("FAIL reset_cyc[%0d] got %0d want 0", k, o_cyc[k]); end
      end
      reset = 1'b1;
   endtask

   task automatic test_single();
      load(0, 84, 'h96);
      pulse_start();
      checks++; if (o_busy[2] !== 1) begin errors++; $display("FAIL single_busy got %0d want 1", o_busy[2]); end
      checks++; if (o_cyc[2] !== 0) begin errors++; $display("FAIL single_cyc0 got %0d want 0", o_cyc[2]); end
      repeat (3) cycle();
      write(84, 'h96);
      checks++; if (o_pass[2] !== 1 || o_done[2] !== 1 || o_busy[2] !== 0) begin
         errors++; $display("FAIL single_pass got pass=%0d done=%0d busy=%0d want 1 1 0", o_pass[2], o_done[2], o_busy[2]); end
      checks++; if (o_mc[2] !== 1) begin errors++; $display("FAIL single_mc got %0d want 1", o_mc[2]); end
      checks++; if (o_cyc[2] !== 4) begin errors++; $display("FAIL single_cyc got %0d want 4", o_cyc[2]); end
      checks++; if (o_mc[0] !== 1 || o_busy[0] !== 1) begin
         errors++; $display("FAIL single_ord_partial got mc=%0d busy=%0d want 1 1", o_mc[0], o_busy[0]); end
      drain();
   endtask

   task automatic test_ordering();
      load(0, 80, 'h7); load(1, 84, 'h96); load(2, 88, 'h11); load(3, 92, 'h22);
      pulse_start();
      write(84, 'h96);
      write(80, 'h7);
      checks++; if (o_mc[0] !== 1 || o_busy[0] !== 1) begin
         errors++; $display("FAIL ord_mc got mc=%0d busy=%0d want 1 1", o_mc[0], o_busy[0]); end
      checks++; if (o_mc[1] !== 2 || o_busy[1] !== 1) begin
         errors++; $display("FAIL any_mc got mc=%0d busy=%0d want 2 1", o_mc[1], o_busy[1]); end
      write(88, 'h11);
      write(92, 'h22);
      checks++; if (o_pass[1] !== 1 || o_mc[1] !== 4 || o_cyc[1] !== 4) begin
         errors++; $display("FAIL any_pass got pass=%0d mc=%0d cyc=%0d want 1 4 4", o_pass[1], o_mc[1], o_cyc[1]); end
      checks++; if (o_pass[2] !== 1 || o_cyc[2] !== 3) begin
         errors++; $display("FAIL one_reload_pass got pass=%0d cyc=%0d want 1 3", o_pass[2], o_cyc[2]); end
      for (int t = 0; t < 40 && o_busy[0] === 32'd1; t++) cycle();
      checks++; if (o_done[0] !== 1 || o_code[0] !== 2 || o_mc[0] !== 1 || o_cyc[0] !== 16) begin
         errors++; $display("FAIL ord_timeout got done=%0d code=%0d mc=%0d cyc=%0d want 1 2 1 16",
                            o_done[0], o_code[0], o_mc[0], o_cyc[0]); end
      drain();
   endtask

   task automatic test_mismatch();
      load(0, 84, 'h96);
      pulse_start();
      write(60, 'h96);
      write(60, 'h95);
      write(84, 'h95);
      for (int k = 0; k < 3; k++) begin
         checks++; if (o_done[k] !== 1 || o_pass[k] !== 0 || o_code[k] !== 1) begin
            errors++; $display("FAIL mismatch_status[%0d] got done=%0d pass=%0d code=%0d want 1 0 1",
                               k, o_done[k], o_pass[k], o_code[k]); end
         checks++; if (o_mc[k] !== 0 || o_cyc[k] !== 3) begin
            errors++; $display("FAIL mismatch_counts[%0d] got mc=%0d cyc=%0d want 0 3", k, o_mc[k], o_cyc[k]); end
      end
   endtask

   task automatic test_timeout_edge();
      pulse_start();
      repeat (7) cycle();
      checks++; if (o_busy[2] !== 1 || o_done[2] !== 0 || o_cyc[2] !== 7) begin
         errors++; $display("FAIL timeout_early got busy=%0d done=%0d cyc=%0d want 1 0 7", o_busy[2], o_done[2], o_cyc[2]); end
      cycle();
      checks++; if (o_done[2] !== 1 || o_code[2] !== 2 || o_cyc[2] !== 8 || o_busy[2] !== 0) begin
         errors++; $display("FAIL timeout_hit got done=%0d code=%0d cyc=%0d busy=%0d want 1 2 8 0",
                            o_done[2], o_code[2], o_cyc[2], o_busy[2]); end
      drain();
      pulse_start();
      repeat (7) cycle();
      write(84, 'h96);
      checks++; if (o_pass[2] !== 1 || o_code[2] !== 0 || o_cyc[2] !== 8) begin
         errors++; $display("FAIL timeout_last_match got pass=%0d code=%0d cyc=%0d want 1 0 8", o_pass[2], o_code[2], o_cyc[2]); end
      drain();
   endtask

   task automatic test_async_reset();
      pulse_start();
      write(84, 'h96);
      checks++; if (o_mc[0] !== 1 || o_busy[0] !== 1) begin
         errors++; $display("FAIL arst_pre got mc=%0d busy=%0d want 1 1", o_mc[0], o_busy[0]); end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         checks++; if (o_busy[k] !== 0 || o_done[k] !== 0 || o_mc[k] !== 0 || o_cyc[k] !== 0) begin
            errors++; $display("FAIL arst_now[%0d] got busy=%0d done=%0d mc=%0d cyc=%0d want 0 0 0 0",
                               k, o_busy[k], o_done[k], o_mc[k], o_cyc[k]); end
      end
      reset = 1'b1;
      // Table was cleared, so a write of zero to address zero satisfies the 1-entry table.
      pulse_start();
      write(0, 0);
      checks++; if (o_pass[2] !== 1 || o_mc[2] !== 1) begin
         errors++; $display("FAIL arst_table_cleared got pass=%0d mc=%0d want 1 1", o_pass[2], o_mc[2]); end
      drain();
      load(0, 84, 'h96);
      pulse_start();
      write(84, 'h96);
      checks++; if (o_pass[2] !== 1 || o_mc[0] !== 1 || o_busy[0] !== 1) begin
         errors++; $display("FAIL arst_rerun got pass2=%0d mc0=%0d busy0=%0d want 1 1 1", o_pass[2], o_mc[0], o_busy[0]); end
      drain();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         start     = ($urandom_range(0, 15) == 0);
         load_en   = ($urandom_range(0, 3) == 0);
         load_idx  = 2'($urandom_range(0, 3));
         load_addr = 32'(4 * $urandom_range(0, 3));
         load_data = 32'($urandom_range(0, 3));
         memwrite  = ($urandom_range(0, 1) == 1);
         dataadr   = 32'(4 * $urandom_range(0, 4));
         writedata = 32'($urandom_range(0, 3));
         cycle();
         for (int k = 0; k < 3; k++) begin
            checks++; if (o_busy[k] !== 32'(m_st[k] == MRun)) begin
               errors++; $display("FAIL rnd_busy[%0d] n=%0d got %0d want %0d", k, n, o_busy[k], m_st[k] == MRun); end
            checks++; if (o_done[k] !== 32'(m_st[k] == MPass || m_st[k] == MFail)) begin
               errors++; $display("FAIL rnd_done[%0d] n=%0d got %0d", k, n, o_done[k]); end
            checks++; if (o_pass[k] !== 32'(m_st[k] == MPass)) begin
               errors++; $display("FAIL rnd_pass[%0d] n=%0d got %0d want %0d", k, n, o_pass[k], m_st[k] == MPass); end
            checks++; if (o_code[k] !== 32'(m_code[k])) begin
               errors++; $display("FAIL rnd_code[%0d] n=%0d got %0d want %0d", k, n, o_code[k], m_code[k]); end
            checks++; if (o_mc[k] !== 32'(m_cnt[k])) begin
               errors++; $display("FAIL rnd_mc[%0d] n=%0d got %0d want %0d", k, n, o_mc[k], m_cnt[k]); end
            checks++; if (o_cyc[k] !== 32'(m_cyc[k])) begin
               errors++; $display("FAIL rnd_cyc[%0d] n=%0d got %0d want %0d", k, n, o_cyc[k], m_cyc[k]); end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_ordering();
      test_mismatch();
      test_timeout_edge();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
